// File: rtl/seven_seg_scanner.sv
// Time-multiplexed driver for a 5-digit common-anode seven-segment display.
// It takes one snapshot of the digits per frame and applies leading-zero blanking and a ghosting guard.
module seven_seg_scanner #(
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD       = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] D5,
  input  logic [3:0] D4,
  input  logic [3:0] D3,
  input  logic [3:0] D2,
  input  logic [3:0] D1,
  input  logic       lzb,
  input  logic       blank,
  output logic [4:0] an,
  output logic [6:0] seg,
  output logic       frame_tick
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] P_LAST  = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] P_GUARD = PW'(GUARD);
  localparam logic [PW-1:0] P_ONE   = PW'(1);

  logic [PW-1:0] p;
  logic [2:0]    idx;
  logic [3:0]    sh5, sh4, sh3, sh2, sh1;
  logic          sh_lzb;

  logic          p_wrap;
  logic          snap;
  logic          show;
  logic          lz4, lz3, lz2, lz1;
  logic [3:0]    cur_digit;
  logic          cur_lz;
  logic [4:0]    an_sel;
  logic [6:0]    seg_sel;

  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA, 4'hB, 4'hC, 4'hD, 4'hE: s = 7'b0111111;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // 0 and F both count as "empty" for the leading-zero chain.
  function automatic logic is_empty(input logic [3:0] d);
    return (d == 4'h0) || (d == 4'hF);
  endfunction

  assign p_wrap = (p == P_LAST);
  assign snap   = (p == '0) && (idx == 3'd0);
  assign show   = !blank && (p >= P_GUARD);

  // Slot prescaler and digit index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p   <= '0;
      idx <= 3'd0;
    end else if (p_wrap) begin
      p   <= '0;
      idx <= (idx == 3'd4) ? 3'd0 : idx + 3'd1;
    end else begin
      p <= p + P_ONE;
    end
  end

  // Frame snapshot: the whole frame renders from these shadows.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh5    <= 4'hF;
      sh4    <= 4'hF;
      sh3    <= 4'hF;
      sh2    <= 4'hF;
      sh1    <= 4'hF;
      sh_lzb <= 1'b0;
    end else if (snap) begin
      sh5    <= D5;
      sh4    <= D4;
      sh3    <= D3;
      sh2    <= D2;
      sh1    <= D1;
      sh_lzb <= lzb;
    end
  end

  // A digit is blanked only while every higher digit is also empty; units never is.
  assign lz4 = sh_lzb && is_empty(sh5);
  assign lz3 = lz4 && is_empty(sh4);
  assign lz2 = lz3 && is_empty(sh3);
  assign lz1 = lz2 && is_empty(sh2);

  always_comb begin
    cur_digit = 4'hF;
    cur_lz    = 1'b0;
    an_sel    = 5'b11111;
    case (idx)
      3'd0: begin cur_digit = sh1; cur_lz = 1'b0; an_sel = 5'b11110; end
      3'd1: begin cur_digit = sh2; cur_lz = lz1;  an_sel = 5'b11101; end
      3'd2: begin cur_digit = sh3; cur_lz = lz2;  an_sel = 5'b11011; end
      3'd3: begin cur_digit = sh4; cur_lz = lz3;  an_sel = 5'b10111; end
      3'd4: begin cur_digit = sh5; cur_lz = lz4;  an_sel = 5'b01111; end
      default: begin cur_digit = 4'hF; cur_lz = 1'b0; an_sel = 5'b11111; end
    endcase
    seg_sel = cur_lz ? 7'b1111111 : decode(cur_digit);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an         <= 5'b11111;
      seg        <= 7'b1111111;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= snap;
      an         <= show ? an_sel : 5'b11111;
      seg        <= show ? seg_sel : 7'b1111111;
    end
  end

endmodule
